// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus-level bit meanings.
// Used by both the target and the initiator blocks.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for an asynchronous bus line, with rise/fall
// detection performed only on the synchronised copy. Flops preset to 1 (idle bus).
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target (slave) answering DEV_ADDR: receives write bytes, returns
// tx_data on reads, open-drain SDA via SDA_oe. SYNC_STAGES must be >= 2.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCL,
  input  logic       SDA_in,
  output logic       SDA_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (CLK),
    .rst_n (RST),
    .din   (SCL),
    .level (scl_level),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (CLK),
    .rst_n (RST),
    .din   (SDA_in),
    .level (sda_level),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_state_e state, state_n;
  logic [2:0] bit_cnt, cnt_n;
  logic [7:0] shift_q, shift_n;
  logic       rw_q, rw_n;
  logic       phase_q, phase_n;
  logic       oe_n, busy_n, rx_valid_n, tx_load_n;
  logic [7:0] rx_data_n;
  logic       scl_high;
  logic       start_det, stop_det;

  // SCL counts as high if it was high at either end of this cycle, so a START
  // coinciding with the SCL fall is still recognised (and wins over the fall).
  assign scl_high  = scl_level | scl_fall;
  assign start_det = sda_fall & scl_high;
  assign stop_det  = sda_rise & scl_high;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      rw_q     <= RW_WRITE;
      phase_q  <= 1'b0;
      SDA_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= cnt_n;
      shift_q  <= shift_n;
      rw_q     <= rw_n;
      phase_q  <= phase_n;
      SDA_oe   <= oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_load  <= tx_load_n;
      busy     <= busy_n;
    end
  end

  // NOTE: every always_comb output is given a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    cnt_n      = bit_cnt;
    shift_n    = shift_q;
    rw_n       = rw_q;
    phase_n    = phase_q;
    oe_n       = SDA_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_load_n  = 1'b0;
    busy_n     = busy;

    if (start_det) begin
      state_n = ADDR;
      cnt_n   = '0;
      phase_n = 1'b0;
      oe_n    = 1'b0;
      busy_n  = 1'b1;
    end else if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_n = {shift_q[6:0], sda_level};
            cnt_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw_n    = sda_level;
              phase_n = 1'b0;
              state_n = (shift_q[6:0] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
            end
          end
        end
        // phase_q marks that the ACK low has been put on the bus.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oe_n    = 1'b1;
              phase_n = 1'b1;
            end else begin
              phase_n = 1'b0;
              if (rw_q == RW_READ) begin
                state_n   = READ;
                tx_load_n = 1'b1;
                shift_n   = tx_data;
                oe_n      = ~tx_data[7];
              end else begin
                state_n = WRITE;
                oe_n    = 1'b0;
              end
            end
          end
        end
        WRITE: begin
          if (scl_rise) begin
            shift_n = {shift_q[6:0], sda_level};
            cnt_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_n  = {shift_q[6:0], sda_level};
              rx_valid_n = 1'b1;
              phase_n    = 1'b0;
              state_n    = WRITE_ACK;
            end
          end
        end
        WRITE_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oe_n    = 1'b1;
              phase_n = 1'b1;
            end else begin
              oe_n    = 1'b0;
              phase_n = 1'b0;
              state_n = WRITE;
            end
          end
        end
        // READ is entered on a fall with bit 7 already driven; the counter
        // wraps to 0 on the 8th rise, so a fall with bit_cnt==0 ends the byte.
        READ: begin
          if (scl_rise) begin
            cnt_n = bit_cnt + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              oe_n    = 1'b0;
              phase_n = 1'b0;
              state_n = READ_ACK;
            end else begin
              shift_n = {shift_q[6:0], 1'b0};
              oe_n    = ~shift_q[6];
            end
          end
        end
        READ_ACK: begin
          if (scl_rise) begin
            if (sda_level == ACK) begin
              tx_load_n = 1'b1;
              shift_n   = tx_data;
              phase_n   = 1'b1;
            end else begin
              state_n = WAIT_STOP;
            end
          end else if (scl_fall && phase_q) begin
            phase_n = 1'b0;
            oe_n    = ~shift_q[7];
            state_n = READ;
          end
        end
        IDLE, WAIT_STOP: begin
          oe_n = 1'b0;
        end
        default: begin
          state_n = IDLE;
          oe_n    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a behavioural initiator drives SCL/SDA with
// an open-drain wired-AND bus model; each scenario task checks its own results.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 100;  // quarter SCL period, 10 CLK cycles

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SCL = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       SDA_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int oe_cycles = 0, rxv_count = 0, txl_count = 0, pulse_errs = 0;
  logic rxv_d = 1'b0, txl_d = 1'b0;

  assign sda_line = sda_m & ~SDA_oe;

  i2c_target #(.DEV_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SCL      (SCL),
    .SDA_in   (sda_line),
    .SDA_oe   (SDA_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  // Activity monitor sampled on the falling CLK edge.
  always @(negedge CLK) begin
    if (SDA_oe)   oe_cycles++;
    if (rx_valid) rxv_count++;
    if (tx_load)  txl_count++;
    if (rx_valid && tx_load) pulse_errs++;
    if (rx_valid && rxv_d)   pulse_errs++;
    if (tx_load && txl_d)    pulse_errs++;
    rxv_d = rx_valid;
    txl_d = tx_load;
  end

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b;
    #Q SCL = 1'b1;
    #(Q/2) s = sda_line;
    #(Q/2) SCL = 1'b0;
    #Q;
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    #Q SCL = 1'b1;
    #Q sda_m = 1'b0;
    #Q SCL = 1'b0;
    #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    #Q SCL = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    acked = (s == ACK);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(ack_bit, s);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (SDA_oe !== 1'b0)    begin errors++; $display("FAIL reset_oe got %b want 0", SDA_oe); end
    checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    checks++; if (tx_load !== 1'b0)   begin errors++; $display("FAIL reset_tx_load got %b want 0", tx_load); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.state); end
    RST = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_write();
    logic a0, a1;
    int r0;
    r0 = rxv_count;
    bus_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_start got %b want 1", busy); end
    write_byte(8'h84, a0);
    write_byte(8'hA5, a1);
    bus_stop();
    checks++; if (a0 !== 1'b1)          begin errors++; $display("FAIL write_addr_ack got %b want 1", a0); end
    checks++; if (a1 !== 1'b1)          begin errors++; $display("FAIL write_data_ack got %b want 1", a1); end
    checks++; if (rx_data !== 8'hA5)    begin errors++; $display("FAIL write_rx_data got %h want a5", rx_data); end
    checks++; if (rxv_count - r0 !== 1) begin errors++; $display("FAIL write_rx_valid_count got %0d want 1", rxv_count - r0); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL write_busy_stop got %b want 0", busy); end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    int o0, r0;
    o0 = oe_cycles;
    r0 = rxv_count;
    bus_start();
    write_byte(8'h86, a0);
    write_byte(8'h55, a1);
    bus_stop();
    checks++; if (a0 !== 1'b0)           begin errors++; $display("FAIL mismatch_addr_ack got %b want 0", a0); end
    checks++; if (oe_cycles - o0 !== 0)  begin errors++; $display("FAIL mismatch_oe_cycles got %0d want 0", oe_cycles - o0); end
    checks++; if (rxv_count - r0 !== 0)  begin errors++; $display("FAIL mismatch_rx_valid got %0d want 0", rxv_count - r0); end
    checks++; if (dut.state !== IDLE)    begin errors++; $display("FAIL mismatch_state got %0d want IDLE", dut.state); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL mismatch_busy got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic a0;
    logic [7:0] d1, d2;
    int t0;
    t0 = txl_count;
    tx_data = 8'h3C;
    bus_start();
    write_byte(8'h85, a0);
    tx_data = 8'hC3;
    read_byte(ACK, d1);
    read_byte(NACK, d2);
    checks++; if (SDA_oe !== 1'b0) begin errors++; $display("FAIL read_release_after_nack got %b want 0", SDA_oe); end
    bus_stop();
    checks++; if (a0 !== 1'b1)          begin errors++; $display("FAIL read_addr_ack got %b want 1", a0); end
    checks++; if (d1 !== 8'h3C)         begin errors++; $display("FAIL read_byte0 got %h want 3c", d1); end
    checks++; if (d2 !== 8'hC3)         begin errors++; $display("FAIL read_byte1 got %h want c3", d2); end
    checks++; if (txl_count - t0 !== 2) begin errors++; $display("FAIL read_tx_load_count got %0d want 2", txl_count - t0); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL read_busy_stop got %b want 0", busy); end
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2;
    logic [7:0] d;
    tx_data = 8'h5A;
    bus_start();
    write_byte(8'h84, a0);
    write_byte(8'h11, a1);
    bus_start();
    write_byte(8'h85, a2);
    read_byte(NACK, d);
    bus_stop();
    checks++; if (a0 !== 1'b1)       begin errors++; $display("FAIL rs_addr_ack got %b want 1", a0); end
    checks++; if (a1 !== 1'b1)       begin errors++; $display("FAIL rs_data_ack got %b want 1", a1); end
    checks++; if (a2 !== 1'b1)       begin errors++; $display("FAIL rs_second_addr_ack got %b want 1", a2); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL rs_rx_data got %h want 11", rx_data); end
    checks++; if (d !== 8'h5A)       begin errors++; $display("FAIL rs_read_byte got %h want 5a", d); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, s;
    int o0, r0;
    tx_data = 8'h00;
    bus_start();
    write_byte(8'h85, a0);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
    sda_m = 1'b1;
    #Q SCL = 1'b1;
    #(Q/2);
    checks++; if (SDA_oe !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_oe got %b want 1", SDA_oe); end
    RST = 1'b0;
    #1;
    checks++; if (SDA_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_async_oe got %b want 0", SDA_oe); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    #50 RST = 1'b1;
    #(Q/2) SCL = 1'b0;
    #Q;
    o0 = oe_cycles;
    r0 = rxv_count;
    for (int i = 0; i < 4; i++) bus_bit(i[0], s);
    write_byte(8'h84, a1);
    checks++; if (a1 !== 1'b0)          begin errors++; $display("FAIL rst_mid_ignored_ack got %b want 0", a1); end
    checks++; if (oe_cycles - o0 !== 0) begin errors++; $display("FAIL rst_mid_ignored_oe got %0d want 0", oe_cycles - o0); end
    checks++; if (rxv_count - r0 !== 0) begin errors++; $display("FAIL rst_mid_ignored_rxv got %0d want 0", rxv_count - r0); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_mid_ignored_busy got %b want 0", busy); end
    bus_stop();
    bus_start();
    write_byte(8'h84, a0);
    write_byte(8'h3E, a1);
    bus_stop();
    checks++; if (a0 !== 1'b1)       begin errors++; $display("FAIL rst_mid_fresh_ack got %b want 1", a0); end
    checks++; if (rx_data !== 8'h3E) begin errors++; $display("FAIL rst_mid_fresh_rx got %h want 3e", rx_data); end
  endtask

  task automatic test_start_with_scl_edge();
    logic a0, a1, a2, s;
    bus_start();
    write_byte(8'h84, a0);
    for (int i = 0; i < 3; i++) bus_bit(1'b0, s);
    sda_m = 1'b1;
    #Q SCL = 1'b1;
    #Q;
    SCL = 1'b0;
    sda_m = 1'b0;
    #Q;
    checks++; if (dut.state !== ADDR)  begin errors++; $display("FAIL start_edge_state got %0d want ADDR", dut.state); end
    checks++; if (dut.bit_cnt !== 3'd0) begin errors++; $display("FAIL start_edge_cnt got %0d want 0", dut.bit_cnt); end
    checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL start_edge_busy got %b want 1", busy); end
    write_byte(8'h84, a1);
    write_byte(8'h77, a2);
    bus_stop();
    checks++; if (a1 !== 1'b1)       begin errors++; $display("FAIL start_edge_addr_ack got %b want 1", a1); end
    checks++; if (a2 !== 1'b1)       begin errors++; $display("FAIL start_edge_data_ack got %b want 1", a2); end
    checks++; if (rx_data !== 8'h77) begin errors++; $display("FAIL start_edge_rx got %h want 77", rx_data); end
  endtask

  task automatic test_pulses();
    checks++; if (pulse_errs !== 0) begin errors++; $display("FAIL pulse_rules got %0d violations want 0", pulse_errs); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_repeated_start();
    test_reset_mid_read();
    test_start_with_scl_edge();
    test_pulses();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h42, 7-bit target address this block answers to.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth on SCL and SDA inputs (minimum 2).
REQ-003 CLK  input  1  system clock; one clock; all state on posedge CLK.
REQ-004 RST  input  1  reset; asynchronous, active-low.
REQ-005 SCL  input  1  bus clock from the initiator; asynchronous to CLK.
REQ-006 SDA_in  input  1  bus data as read back from the pad.
REQ-007 SDA_oe  output  1  1 pulls SDA low (open-drain); 0 releases SDA.
REQ-008 rx_data  output  8  last byte written by the initiator.
REQ-009 rx_valid  output  1  one-CLK pulse; rx_data is new.
REQ-010 tx_data  input  8  byte to return on a read transfer.
REQ-011 tx_load  output  1  one-CLK pulse; tx_data sampled this cycle, and the source may advance.
REQ-012 busy  output  1  high from START until STOP.

Function
REQ-013 SCL and SDA_in pass through SYNC_STAGES flops; rising and falling edges are detected on the synchronised copies only.
REQ-014 START condition: synchronised SDA falls while SCL is high. STOP condition: SDA rises while SCL is high.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
REQ-016 On START in any state (including a repeated START), go to ADDR, clear the bit counter and set busy=1.
REQ-017 On STOP in any state, go to IDLE, set SDA_oe=0 and set busy=0.
REQ-018 Data is sampled on the SCL rising edge, MSB first, with a 3-bit counter; SDA_oe changes only on the SCL falling edge.
REQ-019 ADDR: 8 bits are received (7 address bits, then R/W). On the 8th rise, if the address equals DEV_ADDR, go to ADDR_ACK; otherwise go to WAIT_STOP with SDA_oe kept at 0.
REQ-020 ADDR_ACK: SDA_oe=1 from the next SCL fall to the following SCL fall.
REQ-020a At the end of ADDR_ACK, R/W=0 selects WRITE. R/W=1 selects READ, pulses tx_load and loads tx_data into the shift register.
REQ-021 WRITE: on the 8th rise, update rx_data and pulse rx_valid for one CLK cycle, then go to WRITE_ACK. WRITE_ACK always ACKs (SDA_oe=1 for one SCL low-high-low period), then returns to WRITE.
REQ-022 READ: SDA_oe = ~shift_reg[7], updated on each SCL fall. After 8 bits, release SDA and go to READ_ACK.
REQ-023 READ_ACK: sample SDA on the SCL rise. 0 (ACK) pulses tx_load, reloads the shift register and returns to READ. 1 (NACK) goes to WAIT_STOP.
REQ-024 WAIT_STOP and IDLE: SDA_oe=0; bus activity other than START/STOP is ignored.
REQ-025 START and STOP take priority over a bit edge detected in the same CLK cycle.
REQ-026 rx_valid and tx_load are never asserted in the same cycle, and neither is asserted for more than one cycle.

Reset
REQ-027 While RST=0: state=IDLE, SDA_oe=0, rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, counter=0, and synchronisers preset to 1 (idle bus).
REQ-028 Reset asserted mid-transfer releases SDA immediately (asynchronously). After release, the block waits for a fresh START.

Structure
REQ-029 A shared package i2c_pkg holds the state enumeration and the ACK/NACK and R/W bit constants, shared with the initiator block.
REQ-030 One sub-module, i2c_sync_edge: synchroniser plus rise/fall detector, instantiated once for SCL and once for SDA.

Verification
REQ-031 Write to 7'h42 with byte 8'hA5, then STOP -> ACK on the address and data bits; rx_data=8'hA5; exactly one rx_valid pulse; busy=0 after STOP.
REQ-032 Address 7'h43 -> SDA_oe stays 0 for the whole transfer; no rx_valid; state reaches IDLE at STOP.
REQ-033 Read from 7'h42 with tx_data=8'h3C, initiator ACKs, then tx_data=8'hC3, initiator NACKs, then STOP -> bus carries 3C then C3; tx_load pulses twice; SDA released after the NACK.
REQ-034 Write 8'h11, repeated START, then read -> rx_data=8'h11; second address phase ACKed; read proceeds normally.
REQ-035 RST pulled low during bit 4 of a read byte -> SDA_oe=0 within the same CLK edge; after release, bus edges are ignored until the next START.
REQ-036 START and an SCL edge in the same synchronised cycle -> state=ADDR and counter=0.
